// File: rtl/reaction_input_conditioner.sv
// rtl/reaction_input_conditioner.sv - button debounce, trigger pulses and random delay draw
module reaction_input_conditioner #(
    parameter int          DEBOUNCE_CYCLES = 500,
    parameter logic [15:0] SEED            = 16'hACE1,
    parameter int          MIN_DELAY       = 12500,
    parameter logic [15:0] RANGE_MASK      = 16'h7FFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_start_raw,
    input  logic        btn_user_raw,
    output logic        start_trigger,
    output logic        user_trigger,
    output logic [15:0] random_delay
);

    localparam int          CW        = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [15:0] LFSR_INIT = (SEED == 16'h0000) ? 16'h0001 : SEED;
    localparam logic [15:0] TAPS      = 16'hB400;
    localparam logic [15:0] MIN16     = 16'(MIN_DELAY);

    // Channel 0 is the start button, channel 1 the reaction button.
    logic [1:0]    raw;
    logic [1:0]    s0;
    logic [1:0]    s1;
    logic [1:0]    stable;
    logic [1:0]    trig;
    logic [1:0]    accept;
    logic [CW-1:0] cnt [2];
    logic [15:0]   lfsr;

    assign raw = {btn_user_raw, btn_start_raw};

    always_comb begin
        accept = 2'b00;
        for (int i = 0; i < 2; i++) begin
            accept[i] = (s1[i] != stable[i]) && (cnt[i] == CNT_LAST);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s0     <= 2'b00;
            s1     <= 2'b00;
            stable <= 2'b00;
            trig   <= 2'b00;
            cnt[0] <= '0;
            cnt[1] <= '0;
        end else begin
            s0 <= raw;
            s1 <= s0;
            for (int i = 0; i < 2; i++) begin
                // Only an accepted rising level produces a pulse; releases are silent.
                trig[i] <= accept[i] & s1[i];
                if (s1[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (accept[i]) begin
                    stable[i] <= s1[i];
                    cnt[i]    <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    // Free-running LFSR; press timing picks the sample, so the draw is unpredictable.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr         <= LFSR_INIT;
            random_delay <= MIN16;
        end else begin
            lfsr <= (lfsr >> 1) ^ (lfsr[0] ? TAPS : 16'h0000);
            if (accept[0] && s1[0]) begin
                random_delay <= MIN16 + (lfsr & RANGE_MASK);
            end
        end
    end

    assign start_trigger = trig[0];
    assign user_trigger  = trig[1];

endmodule

// File: doc/reaction_input_conditioner.md
# reaction_input_conditioner

Front-end stage of the reaction-time tester. It turns the two raw push-buttons into clean single-cycle `start_trigger` / `user_trigger` pulses and supplies a pseudo-random 16-bit `random_delay` that is freshly drawn on every start press. Its outputs connect directly to the trigger and delay inputs of the reaction-time benchmark core. It runs in the core's 50 kHz clock domain (50 cycles per ms, 1 LSB of `random_delay` = 4 cycles = 80 µs).

## Interface
- `DEBOUNCE_CYCLES`, 500, consecutive stable samples required to accept a level change (10 ms); legal range ≥ 2.
- `SEED`, 16'hACE1, LFSR reset value; a value of 0 is replaced by 16'h0001.
- `MIN_DELAY`, 12500, lower bound of `random_delay` (1.0 s).
- `RANGE_MASK`, 16'h7FFF, mask applied to the LFSR before it is added; `MIN_DELAY + RANGE_MASK` ≤ 65535 is required.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `btn_start_raw`  in  1  start button, asynchronous, active-high, bouncy.
- `btn_user_raw`  in  1  reaction button, asynchronous, active-high, bouncy.
- `start_trigger`  out  1  one-cycle pulse per accepted start press.
- `user_trigger`  out  1  one-cycle pulse per accepted reaction press.
- `random_delay`  out  16  delay value; valid and updated while `start_trigger` is high.

## Operation
- The two buttons are handled by identical, independent channels.
- Each channel contains:
  - A two-flop synchronizer (`s0`, `s1`).
  - A debounce counter of width clog2(`DEBOUNCE_CYCLES`).
  - A debounced level register `stable`.
- Debounce rules, evaluated every edge:
  - `s1 == stable`: counter <= 0.
  - `s1 != stable` and counter < `DEBOUNCE_CYCLES`-1: counter increments.
  - `s1 != stable` and counter == `DEBOUNCE_CYCLES`-1: `stable` <= `s1`, counter <= 0.
- Pulse generation:
  - The trigger register is set for exactly one cycle at the same edge where `stable` goes 0→1.
  - At every other edge it is cleared.
  - Release (1→0) is debounced the same way but produces no pulse.
- A held button produces one pulse only. A new pulse requires a debounced release followed by a debounced press.
- Glitches shorter than `DEBOUNCE_CYCLES` samples reset the counter and produce no pulse.
- Simultaneous presses are allowed: both triggers may pulse in the same cycle. There is no priority and no suppression; the core decides the meaning (false start, etc.).
- LFSR:
  - 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1 (toggle mask 16'hB400), right-shifting.
  - Each edge: `lfsr <= (lfsr >> 1) ^ (lfsr[0] ? 16'hB400 : 0)`.
  - It free-runs every cycle, so human press timing supplies the entropy.
  - It never reaches 0, and its period is 65535.
- Delay draw: at the edge that sets `start_trigger`, `random_delay` <= `MIN_DELAY` + (`lfsr` & `RANGE_MASK`).
  - `lfsr` here is the register value before that edge.
  - The addition is 16-bit and cannot overflow under the parameter rule.
  - `random_delay` holds its value until the next start pulse.
- There is no state machine beyond the per-channel debounce logic. Channel behaviour is fully described by (`stable`, counter).

## Timing
- Reset (asynchronous, `rst` = 0) values:
  - `start_trigger` = 0, `user_trigger` = 0.
  - `random_delay` = `MIN_DELAY`.
  - `lfsr` = `SEED` (or 1 if `SEED` is 0).
  - Synchronizers = 0, `stable` = 0, counters = 0.
- Reset asserted mid-debounce or during a pulse:
  - All registers clear immediately, without waiting for a clock edge.
  - A button still held at deassertion is seen as a new press once debounced, and produces a pulse.
- Press latency:
  - The raw input is high at rising edge E0. From there the input stays steady.
  - `s1` = 1 after E1.
  - The trigger is high during the cycle after edge E(`DEBOUNCE_CYCLES`+1), and low again after the next edge.
- All outputs are registered; there is no combinational path from any input to any output.
- `random_delay` changes only at an edge where `start_trigger` rises. The core therefore sees the new value in the same cycle it samples `start_trigger`.

## Test plan
Benches use `DEBOUNCE_CYCLES` = 4, `SEED` = 16'hACE1, `MIN_DELAY` = 100, `RANGE_MASK` = 16'h00FF.
- Reset, then no activity:
  - Both triggers stay 0 and `random_delay` = 100.
  - After 1 clock the internal LFSR = 16'hE270.
- Raw start held high from edge E0 for 20 cycles:
  - `start_trigger` is high only in the cycle following E5; exactly one pulse.
  - `random_delay` = 100 + (model LFSR & 8'hFF) and lies in 100..355.
- Bounce on user: pattern 1,0,1,1,0,1,1,1,1 (one sample per cycle), then held:
  - Exactly one `user_trigger`, 4 cycles after the final steady run begins plus 2 synchronizer cycles.
  - No pulse for the earlier runs.
- Both raw inputs rise at the same edge: both triggers pulse in the same cycle.
- Assert `rst` while the start counter = 2:
  - All outputs clear immediately.
  - With the button still held, one pulse follows 6 edges after deassertion.
- 1000 start presses, each with a random gap:
  - Every `random_delay` matches the model and stays within 100..355.
  - The LFSR never reads 0.
